// File: rtl/iter_divider_if.sv
// Request/result bundle for iter_divider: request handshake, kill, result handshake and status.
// The master side belongs to the execute stage, the slave side to the divider.
interface iter_divider_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             kill;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             dbz;
    logic             busy;

    modport master (
        output in_valid, op, a, b, kill, out_ready,
        input  in_ready, out_valid, result, dbz, busy
    );

    modport slave (
        input  in_valid, op, a, b, kill, out_ready,
        output in_ready, out_valid, result, dbz, busy
    );
endinterface

// File: rtl/iter_divider.sv
// Iterative RISC-V DIV/DIVU/REM/REMU unit, UNROLL quotient bits per cycle; DIV_EARLY_OUT_EN skips CALC when |a| < |b|.
// Latency N+2 edges counting the accepting edge (N = WIDTH/UNROLL); special cases 1 edge.
// Accepts only in IDLE; the result is held in DONE until out_ready; kill aborts to IDLE.
module iter_divider #(
    parameter int WIDTH  = 32,
    parameter int UNROLL = 1
) (
    input logic           CLK,
    input logic           RESET,
    iter_divider_if.slave bus
);
    localparam int N  = WIDTH / UNROLL;
    localparam int CW = $clog2(N);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic [1:0]       r_state;
    logic [CW-1:0]    r_cnt;
    logic             r_rem_sel;
    logic             r_qneg;
    logic             r_rneg;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_div;
    logic [WIDTH-1:0] r_result;
    logic             r_dbz;

    logic             w_accept;
    logic             w_signed;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic             w_b_zero;
    logic             w_ovf;
    logic             w_small;
    logic             w_special;
    logic [WIDTH-1:0] w_special_res;
    logic [WIDTH:0]   w_r;
    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_fix_res;

    // Request decode: magnitudes feed CALC directly so the accepting edge is also the load edge.
    always_comb begin
        w_accept  = bus.in_valid & (r_state == S_IDLE) & ~bus.kill;
        w_signed  = ~bus.op[0];
        w_a_neg   = w_signed & bus.a[WIDTH-1];
        w_b_neg   = w_signed & bus.b[WIDTH-1];
        w_a_mag   = w_a_neg ? (~bus.a + 1'b1) : bus.a;
        w_b_mag   = w_b_neg ? (~bus.b + 1'b1) : bus.b;
        w_b_zero  = (bus.b == '0);
        w_ovf     = w_signed & (bus.a == MOST_NEG) & (bus.b == ALL_ONES);
`ifdef DIV_EARLY_OUT_EN
        w_small   = ~w_b_zero & (w_a_mag < w_b_mag);
`else
        w_small   = 1'b0;
`endif
        w_special = w_b_zero | w_ovf | w_small;
    end

    always_comb begin
        w_special_res = '0;
        if (w_b_zero) begin
            w_special_res = bus.op[1] ? bus.a : ALL_ONES;
        end else if (w_ovf) begin
            w_special_res = bus.op[1] ? '0 : bus.a;
        end else if (w_small) begin
            w_special_res = bus.op[1] ? bus.a : '0;
        end
    end

    // Restoring division: the dividend shifts out of r_quo while quotient bits shift in.
    always_comb begin
        w_r = {1'b0, r_rem};
        w_q = r_quo;
        for (int u = 0; u < UNROLL; u++) begin
            w_r = {w_r[WIDTH-1:0], w_q[WIDTH-1]};
            w_q = {w_q[WIDTH-2:0], 1'b0};
            if (w_r >= {1'b0, r_div}) begin
                w_r    = w_r - {1'b0, r_div};
                w_q[0] = 1'b1;
            end
        end
    end

    // A zero magnitude negates to zero, so a zero quotient never comes out negative.
    always_comb begin
        w_fix_res = '0;
        if (r_rem_sel) begin
            w_fix_res = r_rneg ? (~r_rem + 1'b1) : r_rem;
        end else begin
            w_fix_res = r_qneg ? (~r_quo + 1'b1) : r_quo;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_rem_sel <= 1'b0;
            r_qneg    <= 1'b0;
            r_rneg    <= 1'b0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_div     <= '0;
            r_result  <= '0;
            r_dbz     <= 1'b0;
        end else if (bus.kill) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_rem_sel <= bus.op[1];
                        r_qneg    <= w_a_neg ^ w_b_neg;
                        r_rneg    <= w_a_neg;
                        if (w_special) begin
                            r_result <= w_special_res;
                            r_dbz    <= w_b_zero;
                            r_state  <= S_DONE;
                        end else begin
                            r_rem   <= '0;
                            r_quo   <= w_a_mag;
                            r_div   <= w_b_mag;
                            r_cnt   <= CW'(N - 1);
                            r_state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    r_rem <= w_r[WIDTH-1:0];
                    r_quo <= w_q;
                    if (r_cnt == '0) begin
                        r_state <= S_FIX;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_FIX: begin
                    r_result <= w_fix_res;
                    r_dbz    <= 1'b0;
                    r_state  <= S_DONE;
                end
                default: begin
                    if (bus.out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.out_valid = (r_state == S_DONE);
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.result    = r_result;
    assign bus.dbz       = r_dbz;
endmodule

// File: tb/tb_iter_divider.sv
// Directed bench for iter_divider: a 32-bit/UNROLL=1 unit and a 16-bit/UNROLL=2 unit share one driver.
module tb_iter_divider;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

`ifdef DIV_EARLY_OUT_EN
    localparam bit EO = 1'b1;
`else
    localparam bit EO = 1'b0;
`endif

    iter_divider_if #(.WIDTH(32)) b32 ();
    iter_divider_if #(.WIDTH(16)) b16 ();

    iter_divider #(.WIDTH(32), .UNROLL(1)) dut32 (.CLK(clk), .RESET(rst_n), .bus(b32.slave));
    iter_divider #(.WIDTH(16), .UNROLL(2)) dut16 (.CLK(clk), .RESET(rst_n), .bus(b16.slave));

    logic        sel16     = 1'b0;
    logic        drv_valid = 1'b0;
    logic [1:0]  drv_op    = 2'b00;
    logic [31:0] drv_a     = '0;
    logic [31:0] drv_b     = '0;
    logic        drv_kill  = 1'b0;
    logic        drv_ordy  = 1'b0;

    assign b32.in_valid  = drv_valid & ~sel16;
    assign b32.op        = drv_op;
    assign b32.a         = drv_a;
    assign b32.b         = drv_b;
    assign b32.kill      = drv_kill;
    assign b32.out_ready = drv_ordy & ~sel16;
    assign b16.in_valid  = drv_valid & sel16;
    assign b16.op        = drv_op;
    assign b16.a         = drv_a[15:0];
    assign b16.b         = drv_b[15:0];
    assign b16.kill      = drv_kill;
    assign b16.out_ready = drv_ordy & sel16;

    logic        cur_valid, cur_ready, cur_busy, cur_dbz;
    logic [31:0] cur_result;
    always_comb begin
        cur_valid  = sel16 ? b16.out_valid : b32.out_valid;
        cur_ready  = sel16 ? b16.in_ready  : b32.in_ready;
        cur_busy   = sel16 ? b16.busy      : b32.busy;
        cur_dbz    = sel16 ? b16.dbz       : b32.dbz;
        cur_result = sel16 ? {16'h0, b16.result} : b32.result;
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        string       name;
        bit          w16;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        dbz;
        int          lat;
    } vec_t;

    function automatic vec_t mk(input string name, input bit w16, input logic [1:0] op,
                                input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] res, input logic dbz, input int lat);
        vec_t v;
        v.name = name; v.w16 = w16; v.op = op; v.a = a; v.b = b;
        v.res = res; v.dbz = dbz; v.lat = lat;
        return v;
    endfunction

    function automatic int eo_lat(input int full);
        return EO ? 1 : full;
    endfunction

    // lat counts rising edges, the accepting edge being edge 1.
    task automatic issue_and_wait(input bit w16, input logic [1:0] op, input logic [31:0] a,
                                  input logic [31:0] b, output int lat);
        @(negedge clk);
        sel16 = w16; drv_op = op; drv_a = a; drv_b = b; drv_valid = 1'b1;
        @(posedge clk); #1;
        drv_valid = 1'b0;
        lat = 1;
        while (!cur_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic release_result();
        @(negedge clk); drv_ordy = 1'b1;
        @(posedge clk); #1; drv_ordy = 1'b0;
    endtask

    vec_t        vt[$];
    int          lat;
    int          cnt;
    logic [31:0] last32;
    logic [31:0] hold_val;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vt.push_back(mk("div_100_3",      0, 2'b00, 32'd100,      32'd3,        32'd33,       0, 34));
        vt.push_back(mk("rem_100_3",      0, 2'b10, 32'd100,      32'd3,        32'd1,        0, 34));
        vt.push_back(mk("div_m100_3",     0, 2'b00, 32'hFFFFFF9C, 32'd3,        32'hFFFFFFDF, 0, 34));
        vt.push_back(mk("rem_m100_3",     0, 2'b10, 32'hFFFFFF9C, 32'd3,        32'hFFFFFFFF, 0, 34));
        vt.push_back(mk("divu_max_2",     0, 2'b01, 32'hFFFFFFFF, 32'd2,        32'h7FFFFFFF, 0, 34));
        vt.push_back(mk("div_ovf",        0, 2'b00, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0, 1));
        vt.push_back(mk("rem_ovf",        0, 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h0,        0, 1));
        vt.push_back(mk("div_by0",        0, 2'b00, 32'd123,      32'd0,        32'hFFFFFFFF, 1, 1));
        vt.push_back(mk("rem_by0",        0, 2'b10, 32'd123,      32'd0,        32'd123,      1, 1));
        vt.push_back(mk("remu_by0",       0, 2'b11, 32'd7,        32'd0,        32'd7,        1, 1));
        vt.push_back(mk("divu_min_max",   0, 2'b01, 32'h80000000, 32'hFFFFFFFF, 32'h0,        0, eo_lat(34)));
        vt.push_back(mk("div_7_m2",       0, 2'b00, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 0, 34));
        vt.push_back(mk("rem_7_m2",       0, 2'b10, 32'd7,        32'hFFFFFFFE, 32'd1,        0, 34));
        vt.push_back(mk("div_min_2",      0, 2'b00, 32'h80000000, 32'd2,        32'hC0000000, 0, 34));
        vt.push_back(mk("rem_m7_7",       0, 2'b10, 32'hFFFFFFF9, 32'd7,        32'h0,        0, 34));
        vt.push_back(mk("div_m1_2",       0, 2'b00, 32'hFFFFFFFF, 32'd2,        32'h0,        0, eo_lat(34)));
        vt.push_back(mk("rem_m5_9",       0, 2'b10, 32'hFFFFFFFB, 32'd9,        32'hFFFFFFFB, 0, eo_lat(34)));
        vt.push_back(mk("w16_div_min_3",  1, 2'b00, 32'h8000,     32'h0003,     32'hD556,     0, 10));
        vt.push_back(mk("w16_rem_5_9",    1, 2'b10, 32'd5,        32'd9,        32'd5,        0, eo_lat(10)));
        vt.push_back(mk("w16_remu",       1, 2'b11, 32'hFFFF,     32'h0100,     32'h00FF,     0, 10));
        vt.push_back(mk("w16_divu",       1, 2'b01, 32'hFFFF,     32'd3,        32'h5555,     0, 10));
        vt.push_back(mk("w16_div_by0",    1, 2'b01, 32'h1234,     32'd0,        32'hFFFF,     1, 1));

        // Reset state
        #1;
        chk("rst_in_ready",  cur_ready,  1);
        chk("rst_out_valid", cur_valid,  0);
        chk("rst_result",    cur_result, 0);
        chk("rst_dbz",       cur_dbz,    0);
        chk("rst_busy",      cur_busy,   0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        last32 = '0;
        foreach (vt[i]) begin
            logic [31:0] r;
            logic        d;
            issue_and_wait(vt[i].w16, vt[i].op, vt[i].a, vt[i].b, lat);
            r = cur_result;
            d = cur_dbz;
            chk({vt[i].name, "_result"}, r,   vt[i].res);
            chk({vt[i].name, "_dbz"},    d,   vt[i].dbz);
            chk({vt[i].name, "_lat"},    lat, vt[i].lat);
            if (!vt[i].w16) last32 = vt[i].res;
            release_result();
            chk({vt[i].name, "_release"}, cur_valid, 0);
        end

        // kill in IDLE together with in_valid: no accept
        @(negedge clk);
        sel16 = 1'b0; drv_op = 2'b00; drv_a = 32'd50; drv_b = 32'd5;
        drv_valid = 1'b1; drv_kill = 1'b1;
        @(posedge clk); #1;
        chk("kill_idle_busy",     cur_busy,  0);
        chk("kill_idle_in_ready", cur_ready, 1);
        drv_valid = 1'b0; drv_kill = 1'b0;

        // kill on the 5th CALC cycle
        @(negedge clk);
        drv_op = 2'b01; drv_a = 32'd1000; drv_b = 32'd7; drv_valid = 1'b1;
        @(posedge clk); #1;
        drv_valid = 1'b0;
        chk("kill_calc_started", cur_busy, 1);
        repeat (4) @(posedge clk);
        @(negedge clk); drv_kill = 1'b1;
        @(posedge clk); #1;
        drv_kill = 1'b0;
        chk("kill_out_valid", cur_valid,  0);
        chk("kill_in_ready",  cur_ready,  1);
        chk("kill_busy",      cur_busy,   0);
        chk("kill_result",    cur_result, last32);
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (cur_valid) cnt++;
        end
        chk("kill_no_result", cnt, 0);

        // asynchronous reset mid-CALC
        @(negedge clk);
        drv_op = 2'b00; drv_a = 32'd100; drv_b = 32'd3; drv_valid = 1'b1;
        @(posedge clk); #1;
        drv_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_in_ready",  cur_ready,  1);
        chk("arst_out_valid", cur_valid,  0);
        chk("arst_busy",      cur_busy,   0);
        chk("arst_result",    cur_result, 0);
        chk("arst_dbz",       cur_dbz,    0);
        @(negedge clk); rst_n = 1'b1;
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (cur_valid) cnt++;
        end
        chk("arst_no_result", cnt, 0);

        // DONE hold with out_ready low, then release with a new request presented
        issue_and_wait(1'b0, 2'b00, 32'd100, 32'd3, lat);
        chk("hold_lat", lat, 34);
        hold_val = cur_result;
        chk("hold_first", hold_val, 33);
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (cur_result !== 32'd33 || !cur_valid || cur_ready) cnt++;
        end
        chk("hold_stable", cnt, 0);
        @(negedge clk);
        drv_ordy = 1'b1;
        drv_op = 2'b10; drv_a = 32'd100; drv_b = 32'd3; drv_valid = 1'b1;
        @(posedge clk); #1;
        drv_ordy = 1'b0;
        chk("done_exit_valid",  cur_valid, 0);
        chk("done_no_accept",   cur_ready, 1);
        @(posedge clk); #1;
        drv_valid = 1'b0;
        chk("next_accept_busy", cur_busy,  1);
        lat = 1;
        while (!cur_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("next_lat",    lat,        34);
        chk("next_result", cur_result, 1);
        release_result();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/iter_divider.md
Name: iter_divider

Overview:
- Parameterised iterative integer divide/remainder unit; successor to the fixed 32-bit divider inside the ALU.
- Executes RISC-V DIV/DIVU/REM/REMU semantics at generic WIDTH with UNROLL quotient bits retired per cycle.
- Uses valid/ready handshakes on both the input and result sides, plus a pipeline kill input.
- Sits beside the ALU and is driven by the execute stage; the op encoding is the low two bits of the ALU aluc divide codes.

Parameters:
- WIDTH, 32, operand/result width in bits; must be >= 8.
- UNROLL, 1, quotient bits per CALC cycle; legal values 1, 2, 4; must divide WIDTH.

Ports:
- CLK  input  1  clock; all state changes on the rising edge.
- RESET  input  1  asynchronous reset, active-low; clears all state.
- in_valid  input  1  request valid.
- in_ready  output  1  unit can accept a request; high only in IDLE.
- op  input  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- a  input  WIDTH  dividend.
- b  input  WIDTH  divisor.
- kill  input  1  synchronous abort of any in-flight or pending operation.
- out_valid  output  1  result valid; high only in DONE.
- out_ready  input  1  consumer accepts the result.
- result  output  WIDTH  quotient or remainder.
- dbz  output  1  divide-by-zero flag; qualified by out_valid.
- busy  output  1  high in CALC, FIX and DONE.

Behaviour:
- Reset values: in_ready=1, out_valid=0, result=0, dbz=0, busy=0, state=IDLE.
- Accept: request is accepted on a rising edge where in_valid & in_ready & ~kill. op, a and b are registered and need not be held afterwards.
- States:
  - IDLE: on accept, go to DONE if the request is a special case, otherwise go to CALC.
  - CALC: runs N=WIDTH/UNROLL cycles of restoring division on operand magnitudes (unsigned for DIVU/REMU). An iteration counter counts N-1 down to 0; exit to FIX when the counter reaches 0.
  - FIX: applies sign correction and selects the quotient or remainder. Always goes to DONE.
  - DONE: result, dbz and out_valid are held stable until out_ready. On the out_ready edge, go to IDLE with out_valid=0.
- Latency: normal op has out_valid high after the (N+2)th rising edge following the accepting edge. This is 34 at the defaults and 10 for WIDTH=16, UNROLL=2. Special cases have out_valid high after the 1st edge.
- Throughput: at most one op per N+3 cycles. No accept is possible in DONE, even in the same cycle as out_ready.
- Special cases, resolved in IDLE with no CALC:
  - b==0: DIV/DIVU give all ones; REM/REMU give a; dbz=1.
  - Signed overflow, a==most-negative and b==all-ones, for DIV/REM: DIV gives a; REM gives 0; dbz=0.
- Sign rules:
  - Quotient is negative iff the operand signs differ and it is nonzero.
  - Remainder takes the sign of the dividend; truncating division.
  - Magnitudes use a WIDTH-bit two's-complement negate. The most-negative operand magnitude is represented correctly as an unsigned value.
- kill, highest priority: in any state, the next edge forces IDLE with out_valid=0 and busy=0, and the result register is unchanged. If kill is high while in IDLE with in_valid, the request is not accepted.
- Asynchronous reset mid-CALC: outputs immediately take their reset values and no result is emitted.
- in_valid while busy: ignored; the requester must hold it until in_ready.

Optional Feature:
- Macro: DIV_EARLY_OUT_EN.
- Defined: in IDLE, if the unsigned magnitude of a is less than the magnitude of b (b nonzero, including a==0), go directly to DONE. The quotient is 0 and the remainder is a, in original signed form. Latency 1.
- Undefined: these cases take the full CALC path with latency N+2. Results are identical either way.

Test Plan:
- Defaults, op=00, a=100, b=3 -> result=33 after 34 edges, dbz=0. Repeat with op=10 -> result=1.
- op=00, a=0xFFFFFF9C (-100), b=3 -> result=0xFFFFFFDF (-33). op=10, same operands -> result=0xFFFFFFFF (-1). op=01, a=0xFFFFFFFF, b=2 -> result=0x7FFFFFFF.
- op=00, a=0x80000000, b=0xFFFFFFFF -> result=0x80000000 after 1 edge. op=10, same operands -> result=0. op=00, a=123, b=0 -> result=0xFFFFFFFF, dbz=1. op=10, a=123, b=0 -> result=123, dbz=1.
- Accept op=01, a=1000, b=7. Assert kill on the 5th CALC cycle -> IDLE next edge, out_valid never rises, in_ready=1. Drive RESET low mid-CALC -> outputs zero immediately.
- Hold out_ready=0 for 10 cycles in DONE -> result stable, in_ready=0. Then pulse out_ready -> IDLE. The next request is accepted the following cycle.
- WIDTH=16, UNROLL=2, op=00, a=0x8000, b=0x0003 -> result=0xD556 (-10922) after 10 edges. With DIV_EARLY_OUT_EN, op=10, a=5, b=9 -> result=5 after 1 edge.
